snake_matrix_scan: RTL and testbench

Time-multiplexed driver for the 8x8 LED matrix. It consumes the 64-bit playfield image from the game logic and latches one snapshot per frame. It then scans the rows one at a time, with a blanking gap between rows to suppress ghosting, and drives the active-low row and column cathode pins. It sits downstream of `snake_logic`, between the game core and the board pins, and can blink the whole image when the game is over.

---
 rtl/snake_pkg.sv | 17 +
 rtl/snake_scan_timer.sv | 30 +++
 rtl/snake_matrix_scan.sv | 101 ++++++++++
 tb/tb_snake_matrix_scan.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake LED-matrix blocks: matrix geometry, the
// all-off pin pattern, the scan-state encoding and a small sizing helper.
package snake_pkg;

  localparam int MATRIX_DIM = 8;
  localparam logic [7:0] LED_OFF = 8'hFF;

  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_DRIVE = 1'b1
  } scan_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/snake_scan_timer.sv
// Loadable down-counter timing one BLANK or DRIVE interval; o_expire is high
// on the last cycle of the interval, when the count has reached zero.
module snake_scan_timer #(
  parameter int unsigned W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clka,
  input  logic         restart,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_count,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  always_ff @(posedge clka) begin
    if (restart) begin
      r_count <= RST_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count  = r_count;
  assign o_expire = (r_count == '0);

endmodule

// File: rtl/snake_matrix_scan.sv
// Row-scanned driver for the 8x8 LED matrix: latches one image per frame,
// blanks between rows to avoid ghosting, and optionally blinks the image.
module snake_matrix_scan
  import snake_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clka,
  input  logic        restart,
  input  logic [63:0] led_array_flat,
  input  logic        blink_en,
  output logic [7:0]  row_cathode,
  output logic [7:0]  column_cathode,
  output logic [2:0]  row_index,
  output logic        frame_done,
  output scan_state_e dbg_state
);

  localparam int W  = $clog2(max_int(DWELL_CYCLES, BLANK_CYCLES) + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [W-1:0]  BLANK_LOAD = W'(BLANK_CYCLES - 1);
  localparam logic [W-1:0]  DWELL_LOAD = W'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  scan_state_e   r_state;
  logic [2:0]    r_row;
  logic [63:0]   r_frame_buf;
  logic          r_visible;
  logic [BW-1:0] r_bcnt;

  logic [W-1:0]  w_count;
  logic          w_expire;
  logic [W-1:0]  w_load_val;
  logic          w_drive;
  logic          w_first_blank;
  logic          w_frame_end;
  logic [7:0]    w_row_bits;

  assign w_load_val = (r_state == SCAN_BLANK) ? DWELL_LOAD : BLANK_LOAD;

  snake_scan_timer #(
    .W       (W),
    .RST_VAL (BLANK_LOAD)
  ) u_timer (
    .clka       (clka),
    .restart    (restart),
    .i_load     (w_expire),
    .i_load_val (w_load_val),
    .o_count    (w_count),
    .o_expire   (w_expire)
  );

  assign w_drive       = (r_state == SCAN_DRIVE);
  assign w_first_blank = (r_state == SCAN_BLANK) && (r_row == 3'd0) && (w_count == BLANK_LOAD);
  assign w_frame_end   = w_drive && (r_row == 3'd7) && w_expire;

  always_ff @(posedge clka) begin
    if (restart) begin
      r_state     <= SCAN_BLANK;
      r_row       <= 3'd0;
      r_frame_buf <= '0;
      r_visible   <= 1'b1;
      r_bcnt      <= '0;
    end else begin
      // The image only changes at the start of a frame, so a mid-frame update never tears.
      if (w_first_blank) begin
        r_frame_buf <= led_array_flat;
      end
      if (w_expire) begin
        if (r_state == SCAN_BLANK) begin
          r_state <= SCAN_DRIVE;
        end else begin
          r_state <= SCAN_BLANK;
          r_row   <= r_row + 3'd1;
        end
      end
      if (!blink_en) begin
        r_bcnt    <= '0;
        r_visible <= 1'b1;
      end else if (w_frame_end) begin
        if (r_bcnt == BLINK_LAST) begin
          r_bcnt    <= '0;
          r_visible <= ~r_visible;
        end else begin
          r_bcnt <= r_bcnt + BW'(1);
        end
      end
    end
  end

  // Pins decode registered state only; nothing from the inputs reaches them directly.
  assign w_row_bits     = r_frame_buf[{r_row, 3'b000} +: MATRIX_DIM];
  assign row_cathode    = w_drive ? ~(8'b1 << r_row) : LED_OFF;
  assign column_cathode = (w_drive && r_visible) ? ~w_row_bits : LED_OFF;
  assign row_index      = r_row;
  assign frame_done     = w_frame_end;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_snake_matrix_scan.sv
// Directed bench for snake_matrix_scan with short scan parameters; each task
// drives one scenario and checks pins against hand-derived values.
module tb_snake_matrix_scan;
  import snake_pkg::*;

  localparam int DW      = 4;
  localparam int BL      = 2;
  localparam int BF      = 2;
  localparam int ROW_P   = BL + DW;
  localparam int FRAME_P = 8 * ROW_P;

  logic        clka = 1'b0;
  logic        restart = 1'b1;
  logic [63:0] led_array_flat = '0;
  logic        blink_en = 1'b0;
  logic [7:0]  row_cathode;
  logic [7:0]  column_cathode;
  logic [2:0]  row_index;
  logic        frame_done;
  scan_state_e dbg_state;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic [2:0] prev_ri = 3'd0;

  snake_matrix_scan #(
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL),
    .BLINK_FRAMES (BF)
  ) dut (
    .clka           (clka),
    .restart        (restart),
    .led_array_flat (led_array_flat),
    .blink_en       (blink_en),
    .row_cathode    (row_cathode),
    .column_cathode (column_cathode),
    .row_index      (row_index),
    .frame_done     (frame_done),
    .dbg_state      (dbg_state)
  );

  always #5 clka = ~clka;

  function automatic logic [7:0] exp_rc(input int c);
    logic [7:0] one;
    int p;
    int r;
    one = 8'h01;
    p = c % ROW_P;
    r = (c / ROW_P) % 8;
    if (p < BL) return 8'hFF;
    return ~(one << r);
  endfunction

  function automatic bit in_drive(input int c);
    return (c % ROW_P) >= BL;
  endfunction

  // Ghost monitor: at most one row selected, and no row driven while row_index moves.
  always @(negedge clka) begin
    if (mon_en) begin
      if ($countones(~row_cathode) > 1) begin
        failures++;
        $display("FAIL ghost_onehot got=%h exp=at_most_one_zero", row_cathode);
      end
      if (row_index !== prev_ri && row_cathode !== 8'hFF) begin
        failures++;
        $display("FAIL ghost_rowchange got=%h exp=ff", row_cathode);
      end
      prev_ri = row_index;
    end
  end

  // Leaves the caller at the sampling point of cycle 0 after release.
  task automatic apply_reset();
    restart = 1'b1;
    repeat (2) @(posedge clka);
    #1 restart = 1'b0;
    @(negedge clka);
  endtask

  task automatic test_reset();
    led_array_flat = '0;
    blink_en = 1'b0;
    apply_reset();
    mon_en = 1'b1;
    checks++;
    if (row_cathode !== 8'hFF || column_cathode !== 8'hFF || frame_done !== 1'b0 ||
        row_index !== 3'd0 || dbg_state !== SCAN_BLANK) begin
      failures++;
      $display("FAIL reset_state got=%h/%h/%b/%0d exp=ff/ff/0/0",
               row_cathode, column_cathode, frame_done, row_index);
    end
    for (int c = 0; c < FRAME_P; c++) begin
      if (c > 0) @(negedge clka);
      checks++;
      if (row_cathode !== exp_rc(c)) begin
        failures++;
        $display("FAIL reset_rc c=%0d got=%h exp=%h", c, row_cathode, exp_rc(c));
      end
      checks++;
      if (column_cathode !== 8'hFF) begin
        failures++;
        $display("FAIL reset_cc c=%0d got=%h exp=ff", c, column_cathode);
      end
      checks++;
      if (row_index !== 3'((c / ROW_P) % 8)) begin
        failures++;
        $display("FAIL reset_ri c=%0d got=%0d exp=%0d", c, row_index, (c / ROW_P) % 8);
      end
      checks++;
      if (frame_done !== (c == 47)) begin
        failures++;
        $display("FAIL reset_fd c=%0d got=%b exp=%b", c, frame_done, (c == 47));
      end
    end
  endtask

  task automatic test_pixel_map();
    led_array_flat = 64'h8000_0000_0000_0001;
    blink_en = 1'b0;
    apply_reset();
    for (int c = 0; c < FRAME_P; c++) begin
      if (c > 0) @(negedge clka);
      if (c == 2 || c == 5) begin
        checks++;
        if (column_cathode !== 8'hFE) begin
          failures++;
          $display("FAIL pix_row0 c=%0d got=%h exp=fe", c, column_cathode);
        end
      end
      if (c == 20) begin
        checks++;
        if (column_cathode !== 8'hFF) begin
          failures++;
          $display("FAIL pix_row3 c=%0d got=%h exp=ff", c, column_cathode);
        end
      end
      if (c == 44) begin
        checks++;
        if (column_cathode !== 8'h7F || row_cathode !== 8'h7F) begin
          failures++;
          $display("FAIL pix_row7 got=%h/%h exp=7f/7f", column_cathode, row_cathode);
        end
      end
    end
  endtask

  task automatic test_tear_free();
    led_array_flat = '0;
    blink_en = 1'b0;
    apply_reset();
    for (int c = 0; c < 2 * FRAME_P; c++) begin
      if (c > 0) @(negedge clka);
      if (in_drive(c) && c >= 18 && c < FRAME_P) begin
        checks++;
        if (column_cathode !== 8'hFF) begin
          failures++;
          $display("FAIL tear_dark c=%0d got=%h exp=ff", c, column_cathode);
        end
      end
      if (in_drive(c) && c >= FRAME_P) begin
        checks++;
        if (column_cathode !== 8'h00) begin
          failures++;
          $display("FAIL tear_next c=%0d got=%h exp=00", c, column_cathode);
        end
      end
      if (c == 19) led_array_flat = '1;
    end
  endtask

  task automatic test_blink();
    logic [7:0] exp_cc;
    int f;
    led_array_flat = '1;
    blink_en = 1'b1;
    apply_reset();
    for (int c = 0; c <= 297; c++) begin
      if (c > 0) @(negedge clka);
      f = c / FRAME_P;
      if (in_drive(c) && f <= 4) begin
        exp_cc = (f == 2 || f == 3) ? 8'hFF : 8'h00;
        checks++;
        if (column_cathode !== exp_cc) begin
          failures++;
          $display("FAIL blink_frame c=%0d got=%h exp=%h", c, column_cathode, exp_cc);
        end
      end
      if (c == 296) begin
        checks++;
        if (column_cathode !== 8'hFF) begin
          failures++;
          $display("FAIL blink_hidden got=%h exp=ff", column_cathode);
        end
        blink_en = 1'b0;
      end
      if (c == 297) begin
        checks++;
        if (column_cathode !== 8'h00) begin
          failures++;
          $display("FAIL blink_drop got=%h exp=00", column_cathode);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    led_array_flat = '1;
    blink_en = 1'b0;
    apply_reset();
    repeat (32) @(negedge clka);
    checks++;
    if (row_cathode !== 8'hDF || column_cathode !== 8'h00) begin
      failures++;
      $display("FAIL mid_row5 got=%h/%h exp=df/00", row_cathode, column_cathode);
    end
    restart = 1'b1;
    @(posedge clka);
    #1 restart = 1'b0;
    @(negedge clka);
    checks++;
    if (row_cathode !== 8'hFF || column_cathode !== 8'hFF || row_index !== 3'd0 ||
        dbg_state !== SCAN_BLANK) begin
      failures++;
      $display("FAIL mid_reset got=%h/%h/%0d exp=ff/ff/0", row_cathode, column_cathode, row_index);
    end
    for (int c = 0; c < FRAME_P; c++) begin
      if (c > 0) @(negedge clka);
      checks++;
      if (row_cathode !== exp_rc(c)) begin
        failures++;
        $display("FAIL mid_rc c=%0d got=%h exp=%h", c, row_cathode, exp_rc(c));
      end
      checks++;
      if (frame_done !== (c == 47)) begin
        failures++;
        $display("FAIL mid_fd c=%0d got=%b exp=%b", c, frame_done, (c == 47));
      end
    end
  endtask

  initial begin
    test_reset();
    test_pixel_map();
    test_tear_free();
    test_blink();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
